// File: rtl/serialrx.sv
// UART receiver (8N1-style, FRAME data bits, LSB first) with a Wishbone slave
// exposing a one-deep receive register, sticky error flags and a byte counter.
`timescale 1ns/1ps

module serialrx #(
  parameter int DIVIDE = 2,
  parameter int FRAME  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_data_w,
  output logic [31:0] wb_data_r,
  input  logic        wb_we,
  input  logic        wb_stb,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic        wb_stall
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int IW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(DIVIDE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(DIVIDE - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(FRAME - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state;
  logic             sync1;
  logic             rx_s;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [FRAME-1:0] shreg;
  logic             good_stb;
  logic             err_stb;

  logic             rx_valid;
  logic             overrun;
  logic             ferr;
  logic [31:0]      num_bytes;
  logic [FRAME-1:0] data_q;

  logic             req;
  logic             rd_data;
  logic             rd_stat;
  logic [31:0]      data_word;
  logic [31:0]      status_word;
  logic             unused_bits;

  assign wb_stall    = 1'b0;
  assign unused_bits = ^{wb_data_w, wb_addr[31:3], wb_addr[1:0]};

  // Two-flop synchronizer; preset high so reset looks like an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      shreg    <= '0;
      good_stb <= 1'b0;
      err_stb  <= 1'b0;
    end else begin
      good_stb <= 1'b0;
      err_stb  <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state <= S_DATA;
              idx   <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == FULL_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == LAST_BIT) state <= S_STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              good_stb <= 1'b1;
              state    <= S_IDLE;
            end else begin
              err_stb <= 1'b1;
              state   <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req     = wb_cyc && wb_stb;
  assign rd_data = req && !wb_we && !wb_addr[2];
  assign rd_stat = req && !wb_we &&  wb_addr[2];

  always_comb begin
    data_word              = '0;
    data_word[31]          = rx_valid;
    data_word[FRAME-1:0]   = data_q;
    status_word            = '0;
    status_word[0]         = rx_valid;
    status_word[1]         = overrun;
    status_word[2]         = ferr;
    status_word[31:16]     = num_bytes[15:0];
  end

  // Set events are written after the read-clears so a coincident set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack    <= 1'b0;
      wb_data_r <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      ferr      <= 1'b0;
      num_bytes <= '0;
      data_q    <= '0;
    end else begin
      wb_ack    <= req;
      wb_data_r <= '0;
      if (rd_data) wb_data_r <= data_word;
      if (rd_stat) wb_data_r <= status_word;

      if (rd_data) rx_valid <= 1'b0;
      if (rd_stat) begin
        overrun <= 1'b0;
        ferr    <= 1'b0;
      end

      if (good_stb) begin
        num_bytes <= num_bytes + 32'd1;
        if (!rx_valid || rd_data) begin
          data_q   <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (err_stb) ferr <= 1'b1;
    end
  end

endmodule
